// File: rtl/csi_hdmi_sync_if.sv
// Framing, FIFO-level and status signals between the CSI front end and the
// camera-domain sync sequencer.
interface csi_hdmi_sync_if #(
  parameter int FIFO_AW = 12
);
  logic               csi_in_frame;
  logic               csi_in_line;
  logic               rgb_reading;
  logic [FIFO_AW-1:0] fifo_wr_count;
  logic               err_clr;
  logic               rgb_valid;
  logic               hdmi_reset_n;
  logic               fifo_flush;
  logic [10:0]        line_count;
  logic [15:0]        frame_count;
  logic               err_overflow;
  logic               err_line_len;

  modport master (
    output csi_in_frame, csi_in_line, rgb_reading, fifo_wr_count, err_clr,
    input  rgb_valid, hdmi_reset_n, fifo_flush, line_count, frame_count,
           err_overflow, err_line_len
  );

  modport slave (
    input  csi_in_frame, csi_in_line, rgb_reading, fifo_wr_count, err_clr,
    output rgb_valid, hdmi_reset_n, fifo_flush, line_count, frame_count,
           err_overflow, err_line_len
  );
endinterface

// File: rtl/csi_hdmi_sync_ctrl.sv
// Camera-clock sequencer: tracks CSI frame/line framing, gates RGB output and
// the HDMI timing reset, and forces a resync when the line FIFO overflows.
module csi_hdmi_sync_ctrl #(
  parameter int SKIP_LINES   = 3,
  parameter int RELEASE_LINE = 1,
  parameter int MAX_LINES    = 1300,
  parameter int LINE_PIXELS  = 1920,
  parameter int FIFO_AW      = 12,
  parameter int HI_WM        = 4000
) (
  input logic           clk,
  input logic           reset,
  csi_hdmi_sync_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_WAIT_SOF = 3'd1;
  localparam logic [2:0] S_PRE      = 3'd2;
  localparam logic [2:0] S_SKIP     = 3'd3;
  localparam logic [2:0] S_ACTIVE   = 3'd4;
  localparam logic [2:0] S_RESYNC   = 3'd5;

  localparam logic [10:0]        MAX_LC     = 11'(MAX_LINES);
  localparam logic [10:0]        RELEASE_LC = 11'(RELEASE_LINE);
  localparam logic [10:0]        SKIP_LC    = 11'(SKIP_LINES);
  localparam logic [11:0]        LINE_PIX   = 12'(LINE_PIXELS);
  localparam logic [FIFO_AW-1:0] HI_WM_V    = FIFO_AW'(HI_WM);

  logic        frame_q, frame_qq, line_q, line_qq;
  logic        line_rise, line_fall, frame_rise;
  logic [2:0]  state, state_nxt;
  logic [10:0] line_cnt, line_cnt_nxt;
  logic [11:0] pix_cnt;
  logic [15:0] frame_cnt;
  logic        frame_done, ovf_event, len_event;
  logic        rgb_valid_r, hdmi_reset_n_r, fifo_flush_r;
  logic        err_overflow_r, err_line_len_r;

  assign line_rise  = line_q & ~line_qq;
  assign line_fall  = ~line_q & line_qq;
  assign frame_rise = frame_q & ~frame_qq;

  // Frame registers reset high so a frame already in progress at reset
  // release is never mistaken for a fresh start-of-frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_q  <= 1'b1;
      frame_qq <= 1'b1;
      line_q   <= 1'b0;
      line_qq  <= 1'b0;
    end else begin
      frame_q  <= bus.csi_in_frame;
      frame_qq <= frame_q;
      line_q   <= bus.csi_in_line;
      line_qq  <= line_q;
    end
  end

  // Lines seen while still in IDLE belong to a frame we joined mid-way.
  always_comb begin
    line_cnt_nxt = line_cnt;
    if (!frame_q)
      line_cnt_nxt = '0;
    else if (line_rise && state != S_IDLE && line_cnt < MAX_LC)
      line_cnt_nxt = line_cnt + 11'd1;
  end

  // Thresholds use the next line count so the state moves together with it.
  always_comb begin
    state_nxt  = state;
    frame_done = 1'b0;
    ovf_event  = 1'b0;
    case (state)
      S_IDLE:     if (!frame_q) state_nxt = S_WAIT_SOF;
      S_WAIT_SOF: if (frame_rise) state_nxt = S_PRE;
      S_PRE: begin
        if (!frame_q)                        state_nxt = S_WAIT_SOF;
        else if (line_cnt_nxt >= RELEASE_LC) state_nxt = S_SKIP;
      end
      S_SKIP: begin
        if (!frame_q)                     state_nxt = S_WAIT_SOF;
        else if (line_cnt_nxt >= SKIP_LC) state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (!frame_q) begin
          state_nxt  = S_WAIT_SOF;
          frame_done = 1'b1;
        end else if (bus.fifo_wr_count >= HI_WM_V) begin
          state_nxt = S_RESYNC;
          ovf_event = 1'b1;
        end
      end
      S_RESYNC:   if (!frame_q) state_nxt = S_WAIT_SOF;
      default:    state_nxt = S_IDLE;
    endcase
  end

  assign len_event = line_fall && (state == S_ACTIVE) && (pix_cnt != LINE_PIX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= S_IDLE;
      line_cnt       <= '0;
      pix_cnt        <= '0;
      frame_cnt      <= '0;
      err_overflow_r <= 1'b0;
      err_line_len_r <= 1'b0;
    end else begin
      state    <= state_nxt;
      line_cnt <= line_cnt_nxt;
      if (line_rise)
        pix_cnt <= '0;
      else if (line_q && bus.rgb_reading && pix_cnt != 12'hFFF)
        pix_cnt <= pix_cnt + 12'd1;
      if (frame_done)
        frame_cnt <= frame_cnt + 16'd1;
      err_overflow_r <= ovf_event | (err_overflow_r & ~bus.err_clr);
      err_line_len_r <= len_event | (err_line_len_r & ~bus.err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_valid_r    <= 1'b0;
      hdmi_reset_n_r <= 1'b0;
      fifo_flush_r   <= 1'b1;
    end else begin
      rgb_valid_r    <= (state == S_ACTIVE);
      hdmi_reset_n_r <= (state == S_SKIP) || (state == S_ACTIVE);
      fifo_flush_r   <= (state == S_IDLE) || (state == S_WAIT_SOF) ||
                        (state == S_RESYNC);
    end
  end

  assign bus.rgb_valid    = rgb_valid_r;
  assign bus.hdmi_reset_n = hdmi_reset_n_r;
  assign bus.fifo_flush   = fifo_flush_r;
  assign bus.line_count   = line_cnt;
  assign bus.frame_count  = frame_cnt;
  assign bus.err_overflow = err_overflow_r;
  assign bus.err_line_len = err_line_len_r;

endmodule

// File: tb/tb_csi_hdmi_sync_ctrl.sv
// Self-checking bench for csi_hdmi_sync_ctrl: frame/line stimulus with random
// gaps, strobe counts and FIFO levels against a frame-level reference model.
module tb_csi_hdmi_sync_ctrl;

  localparam int SKIP_LINES   = 3;
  localparam int RELEASE_LINE = 1;
  localparam int MAX_LINES    = 1300;
  localparam int LINE_PIXELS  = 1920;
  localparam int FIFO_AW      = 12;
  localparam int HI_WM        = 4000;

  localparam int M_TRACK = 0;
  localparam int M_IDLE  = 1;
  localparam int M_DEAD  = 2;

  logic clk = 1'b0;
  logic reset;

  csi_hdmi_sync_if #(.FIFO_AW(FIFO_AW)) bus ();

  csi_hdmi_sync_ctrl #(
    .SKIP_LINES(SKIP_LINES), .RELEASE_LINE(RELEASE_LINE), .MAX_LINES(MAX_LINES),
    .LINE_PIXELS(LINE_PIXELS), .FIFO_AW(FIFO_AW), .HI_WM(HI_WM)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int compareCount  = 0;
  int mismatchCount = 0;
  int modelFrames   = 0;
  bit modelErrLen   = 1'b0;
  bit modelErrOvf   = 1'b0;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, want %0d", tag, observed, expected);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, "_rgb_valid"}, bus.rgb_valid, 0);
    checkOutput({tag, "_hdmi_reset_n"}, bus.hdmi_reset_n, 0);
    checkOutput({tag, "_fifo_flush"}, bus.fifo_flush, 1);
  endtask

  task automatic clearErrors();
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    tick(1);
    modelErrLen = 1'b0;
    modelErrOvf = 1'b0;
    checkOutput("clr_err_line_len", bus.err_line_len, 0);
    checkOutput("clr_err_overflow", bus.err_overflow, 0);
  endtask

  task automatic applyFrameStart(input int mode);
    bus.csi_in_frame = 1'b1;
    tick(4);
    if (mode == M_TRACK)
      checkOutput("sof_fifo_flush", bus.fifo_flush, 0);
  endtask

  task automatic applyFrameEnd(input int nLines, input int mode);
    tick(2);
    bus.csi_in_frame = 1'b0;
    tick(4);
    if (mode == M_TRACK && nLines >= SKIP_LINES)
      modelFrames++;
    checkOutput("eof_frame_count", bus.frame_count, modelFrames & 32'hFFFF);
    checkOutput("eof_line_count", bus.line_count, 0);
    checkOutput("eof_err_overflow", bus.err_overflow, modelErrOvf);
    checkIdleOutputs("eof");
    tick($urandom_range(3, 8));
  endtask

  // One CSI line, idx being its 1-based position within the frame.
  task automatic applyStimulus(input int strobes, input int idx, input int mode);
    int prev;
    prev = idx - 1;
    if (mode == M_TRACK)
      bus.fifo_wr_count = 12'($urandom_range(0, HI_WM - 1));
    bus.csi_in_line = 1'b1;
    tick(2);
    if (mode == M_TRACK) begin
      checkOutput("line_count", bus.line_count, (idx > MAX_LINES) ? MAX_LINES : idx);
      checkOutput("hdmi_reset_n_before", bus.hdmi_reset_n, 32'(prev >= RELEASE_LINE));
      checkOutput("rgb_valid_before", bus.rgb_valid, 32'(prev >= SKIP_LINES));
    end
    tick(1);
    if (mode == M_TRACK) begin
      checkOutput("hdmi_reset_n_after", bus.hdmi_reset_n, 32'(idx >= RELEASE_LINE));
      checkOutput("rgb_valid_after", bus.rgb_valid, 32'(idx >= SKIP_LINES));
    end else begin
      if (mode == M_IDLE)
        checkOutput("idle_line_count", bus.line_count, 0);
      checkIdleOutputs("dead");
    end
    for (int i = 0; i < strobes; i++) begin
      bus.rgb_reading = 1'b1;
      tick(1);
    end
    bus.rgb_reading = 1'b0;
    tick(2);
    bus.csi_in_line = 1'b0;
    tick(3 + $urandom_range(0, 3));
    if (mode == M_TRACK && idx >= SKIP_LINES && strobes != LINE_PIXELS)
      modelErrLen = 1'b1;
    checkOutput("err_line_len", bus.err_line_len, modelErrLen);
  endtask

  initial begin
    int nLines;
    int pick;
    reset = 1'b1;
    bus.csi_in_frame  = 1'b0;
    bus.csi_in_line   = 1'b0;
    bus.rgb_reading   = 1'b0;
    bus.fifo_wr_count = '0;
    bus.err_clr       = 1'b0;
    tick(3);
    checkIdleOutputs("reset");
    checkOutput("reset_line_count", bus.line_count, 0);
    checkOutput("reset_frame_count", bus.frame_count, 0);
    checkOutput("reset_err_overflow", bus.err_overflow, 0);
    checkOutput("reset_err_line_len", bus.err_line_len, 0);
    reset = 1'b0;

    $display("[TB] basic frame");
    tick(10);
    applyFrameStart(M_TRACK);
    for (int l = 1; l <= 5; l++) applyStimulus(LINE_PIXELS, l, M_TRACK);
    applyFrameEnd(5, M_TRACK);

    $display("[TB] reset released mid-frame");
    bus.csi_in_frame = 1'b1;
    tick(3);
    bus.csi_in_line = 1'b1;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    modelFrames = 0;
    modelErrLen = 1'b0;
    modelErrOvf = 1'b0;
    bus.csi_in_line = 1'b0;
    tick(3);
    for (int l = 1; l <= 3; l++) applyStimulus(20, l, M_IDLE);
    applyFrameEnd(3, M_IDLE);
    applyFrameStart(M_TRACK);
    for (int l = 1; l <= 4; l++) applyStimulus(LINE_PIXELS, l, M_TRACK);
    applyFrameEnd(4, M_TRACK);

    $display("[TB] line length errors");
    applyFrameStart(M_TRACK);
    applyStimulus(LINE_PIXELS, 1, M_TRACK);
    applyStimulus(LINE_PIXELS, 2, M_TRACK);
    applyStimulus(LINE_PIXELS - 1, 3, M_TRACK);
    clearErrors();
    applyStimulus(LINE_PIXELS + 1, 4, M_TRACK);
    applyStimulus(LINE_PIXELS, 5, M_TRACK);
    applyFrameEnd(5, M_TRACK);
    clearErrors();

    $display("[TB] FIFO overflow");
    applyFrameStart(M_TRACK);
    for (int l = 1; l <= 4; l++) applyStimulus(LINE_PIXELS, l, M_TRACK);
    bus.fifo_wr_count = 12'(HI_WM - 1);
    tick(5);
    checkOutput("wm_minus1_rgb_valid", bus.rgb_valid, 1);
    checkOutput("wm_minus1_err_overflow", bus.err_overflow, 0);
    bus.fifo_wr_count = 12'(HI_WM);
    tick(1);
    modelErrOvf = 1'b1;
    checkOutput("ovf_err_overflow", bus.err_overflow, 1);
    tick(1);
    checkIdleOutputs("ovf");
    bus.fifo_wr_count = '0;
    applyStimulus(10, 5, M_DEAD);
    applyFrameEnd(5, M_DEAD);
    applyFrameStart(M_TRACK);
    for (int l = 1; l <= 4; l++) applyStimulus(LINE_PIXELS, l, M_TRACK);
    applyFrameEnd(4, M_TRACK);
    clearErrors();

    $display("[TB] frame dropped in SKIP");
    applyFrameStart(M_TRACK);
    applyStimulus(LINE_PIXELS, 1, M_TRACK);
    applyStimulus(LINE_PIXELS, 2, M_TRACK);
    applyFrameEnd(2, M_TRACK);

    $display("[TB] random frames");
    for (int f = 0; f < 3; f++) begin
      nLines = $urandom_range(0, 4);
      applyFrameStart(M_TRACK);
      for (int l = 1; l <= nLines; l++) begin
        pick = $urandom_range(0, 3);
        applyStimulus((pick == 0) ? LINE_PIXELS - 1 :
                      (pick == 1) ? LINE_PIXELS + 1 : LINE_PIXELS, l, M_TRACK);
      end
      applyFrameEnd(nLines, M_TRACK);
    end
    clearErrors();

    $display("[TB] line count saturation");
    applyFrameStart(M_TRACK);
    for (int l = 0; l < 1399; l++) begin
      bus.csi_in_line = 1'b1;
      tick(1);
      bus.csi_in_line = 1'b0;
      tick(1);
    end
    tick(3);
    modelErrLen = 1'b1;
    checkOutput("sat_line_count", bus.line_count, MAX_LINES);
    checkOutput("sat_err_line_len", bus.err_line_len, 1);
    checkOutput("sat_rgb_valid", bus.rgb_valid, 1);
    clearErrors();
    bus.csi_in_line = 1'b1;
    tick(1);
    bus.csi_in_line = 1'b0;
    tick(1);
    bus.err_clr = 1'b1;
    tick(1);
    bus.err_clr = 1'b0;
    modelErrLen = 1'b1;
    checkOutput("set_wins_err_line_len", bus.err_line_len, 1);
    checkOutput("sat_line_count_final", bus.line_count, MAX_LINES);
    applyFrameEnd(1400, M_TRACK);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
